// File: rtl/ir_pkg.sv
// ir_pkg: shared NEC IR definitions.
// Holds the field offsets inside a 32-bit NEC frame and the decoded
// {address, command} record. Shared by the decoder and, when it is
// refactored, by the receiver.
package ir_pkg;

  // Bit offsets of each byte field in an 8-bit-per-field NEC frame.
  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned NADDR_LSB = 8;
  localparam int unsigned CMD_LSB   = 16;
  localparam int unsigned NCMD_LSB  = 24;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
  } ir_cmd_t;

endpackage

// File: rtl/ir_sync_fifo.sv
// ir_sync_fifo: single-clock FIFO with a registered "last popped" word.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clr            synchronous clear (empties FIFO; wins over push)
//   push/push_data write request and data (dropped when full unless popping)
//   pop            read request (ignored when empty)
//   head_data      head entry, or the last popped entry while empty
//   count          occupancy, full, empty
module ir_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push & (~full | do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        last_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // While empty the read pointer already points past the popped word,
  // so the held value comes from last_q instead of memory.
  assign head_data = empty ? last_q : mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/ir_cmd_decoder.sv
// ir_cmd_decoder: post-processing of NEC receiver frames.
// Detects each newly decoded frame, validates address/command against
// their inverses, applies an optional address filter and queues accepted
// {address, command} pairs in a FIFO with a ready/valid output.
// Ports:
//   i_clkDiv_dec_clk   clock; i_dec_rst_n synchronous active-low reset
//   i_dec_frame_valid  receiver valid level; i_dec_frame receiver frame
//   i_dec_clr          clears FIFO, overflow flag and error counter
//   i_dec_ready        consumer ready
//   o_dec_valid/addr/cmd  FIFO head handshake
//   o_dec_count        FIFO occupancy
//   o_dec_overflow     sticky: accepted frame dropped on a full FIFO
//   o_dec_err_cnt      saturating count of frames failing validation
module ir_cmd_decoder
  import ir_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           FIFO_DEPTH     = 4,
  parameter int unsigned           ADDR_CHK_EN    = 1,
  parameter int unsigned           ADDR_FILTER_EN = 0,
  parameter logic [DATA_WIDTH-1:0] ADDR_MATCH     = '0
) (
  input  logic                          i_clkDiv_dec_clk,
  input  logic                          i_dec_rst_n,
  input  logic                          i_dec_frame_valid,
  input  logic [DATA_WIDTH*4-1:0]       i_dec_frame,
  input  logic                          i_dec_clr,
  input  logic                          i_dec_ready,
  output logic                          o_dec_valid,
  output logic [DATA_WIDTH-1:0]         o_dec_addr,
  output logic [DATA_WIDTH-1:0]         o_dec_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   o_dec_count,
  output logic                          o_dec_overflow,
  output logic [7:0]                    o_dec_err_cnt
);

  localparam int unsigned FW     = DATA_WIDTH * 4;
  // Package offsets are for 8-bit fields; scale them to DATA_WIDTH.
  localparam int unsigned A_OFS  = ADDR_LSB  * DATA_WIDTH / 8;
  localparam int unsigned NA_OFS = NADDR_LSB * DATA_WIDTH / 8;
  localparam int unsigned C_OFS  = CMD_LSB   * DATA_WIDTH / 8;
  localparam int unsigned NC_OFS = NCMD_LSB  * DATA_WIDTH / 8;

  // Stage A
  logic          valid_q, valid_d, valid_qq, valid_dd;
  logic [FW-1:0] frame_q, frame_d, frame_qq, frame_dd;
  // Stage B
  logic                  ev_b_q, ev_b_d;
  logic                  ok_b_q, ok_b_d;
  logic [DATA_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] cmd_b_q, cmd_b_d;
  // Status
  logic       overflow_q, overflow_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic                  new_ev, frame_ok, filter_pass, push, pop;
  logic [DATA_WIDTH-1:0] f_addr, f_naddr, f_cmd, f_ncmd;
  logic [2*DATA_WIDTH-1:0] head_data;
  logic                  fifo_full, fifo_empty;

  always_comb begin
    valid_d  = i_dec_frame_valid;
    frame_d  = i_dec_frame;
    valid_dd = valid_q;
    frame_dd = frame_q;

    f_addr  = frame_q[A_OFS  +: DATA_WIDTH];
    f_naddr = frame_q[NA_OFS +: DATA_WIDTH];
    f_cmd   = frame_q[C_OFS  +: DATA_WIDTH];
    f_ncmd  = frame_q[NC_OFS +: DATA_WIDTH];

    new_ev   = valid_q & (~valid_qq | (frame_q != frame_qq));
    frame_ok = (f_cmd == ~f_ncmd) & ((ADDR_CHK_EN == 0) | (f_addr == ~f_naddr));

    ev_b_d   = new_ev;
    ok_b_d   = frame_ok;
    addr_b_d = f_addr;
    cmd_b_d  = f_cmd;

    filter_pass = (ADDR_FILTER_EN == 0) | (addr_b_q == ADDR_MATCH);
    push        = ev_b_q & ok_b_q & filter_pass;
    pop         = ~fifo_empty & i_dec_ready;

    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    if (i_dec_clr) begin
      err_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (new_ev && !frame_ok && err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (push && fifo_full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clkDiv_dec_clk) begin
    if (!i_dec_rst_n) begin
      valid_q    <= 1'b0;
      frame_q    <= '0;
      valid_qq   <= 1'b0;
      frame_qq   <= '0;
      ev_b_q     <= 1'b0;
      ok_b_q     <= 1'b0;
      addr_b_q   <= '0;
      cmd_b_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      valid_qq   <= valid_dd;
      frame_qq   <= frame_dd;
      ev_b_q     <= ev_b_d;
      ok_b_q     <= ok_b_d;
      addr_b_q   <= addr_b_d;
      cmd_b_q    <= cmd_b_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  ir_sync_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clkDiv_dec_clk),
    .rst_n     (i_dec_rst_n),
    .clr       (i_dec_clr),
    .push      (push),
    .push_data ({addr_b_q, cmd_b_q}),
    .pop       (pop),
    .head_data (head_data),
    .count     (o_dec_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_dec_valid    = ~fifo_empty;
  assign o_dec_addr     = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign o_dec_cmd      = head_data[DATA_WIDTH-1:0];
  assign o_dec_overflow = overflow_q;
  assign o_dec_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ir_cmd_decoder.sv
module tb_ir_cmd_decoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  MATCH = 8'h04;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fvalid;
  logic [31:0] frame;
  logic        clr;
  logic        ready;
  logic        o_valid;
  logic [7:0]  o_addr;
  logic [7:0]  o_cmd;
  logic [2:0]  o_count;
  logic        o_ovf;
  logic [7:0]  o_err;

  always #5 clk = ~clk;

  ir_cmd_decoder #(
    .DATA_WIDTH     (8),
    .FIFO_DEPTH     (DEPTH),
    .ADDR_CHK_EN    (1),
    .ADDR_FILTER_EN (1),
    .ADDR_MATCH     (MATCH)
  ) dut (
    .i_clkDiv_dec_clk  (clk),
    .i_dec_rst_n       (rst_n),
    .i_dec_frame_valid (fvalid),
    .i_dec_frame       (frame),
    .i_dec_clr         (clr),
    .i_dec_ready       (ready),
    .o_dec_valid       (o_valid),
    .o_dec_addr        (o_addr),
    .o_dec_cmd         (o_cmd),
    .o_dec_count       (o_count),
    .o_dec_overflow    (o_ovf),
    .o_dec_err_cnt     (o_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model: queue of accepted {addr,cmd}, status values and a
  // small schedule of effects keyed by the edge on which they take effect.
  logic [15:0] mq[$];
  int unsigned m_err;
  bit          m_ovf;
  logic [15:0] m_last;
  bit          prev_v;
  logic [31:0] prev_f;
  bit          s_err  [4];
  bit          s_push [4];
  logic [15:0] s_data [4];
  int unsigned cyc = 0;

  function automatic logic [31:0] mk(logic [7:0] a, logic [7:0] c, bit ga, bit gc);
    logic [7:0] na, nc;
    na = ga ? ~a : (~a ^ 8'h01);
    nc = gc ? ~c : c;
    return {nc, c, na, a};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int unsigned slot, sz;
    bit e, p, popped, ok;
    logic [15:0] d;
    logic [7:0] a, na, c, nc;
    slot = cyc % 4;
    if (!rst_n) begin
      mq.delete();
      m_err = 0; m_ovf = 0; m_last = '0; prev_v = 0; prev_f = '0;
      for (int i = 0; i < 4; i++) begin s_err[i] = 0; s_push[i] = 0; s_data[i] = '0; end
    end else begin
      e = s_err[slot]; p = s_push[slot]; d = s_data[slot];
      s_err[slot] = 0; s_push[slot] = 0;
      if (clr) begin
        mq.delete();
        m_err = 0;
        m_ovf = 0;
      end else begin
        sz = mq.size();
        popped = ready && (sz > 0);
        if (popped) begin
          m_last = mq[0];
          void'(mq.pop_front());
        end
        if (p) begin
          if (sz < DEPTH || popped) mq.push_back(d);
          else m_ovf = 1;
        end
        if (e && m_err < 255) m_err++;
      end
      // New-frame detection on the values sampled at this edge.
      if (fvalid && (!prev_v || frame != prev_f)) begin
        a = frame[7:0]; na = frame[15:8]; c = frame[23:16]; nc = frame[31:24];
        ok = (c == ~nc) && (a == ~na);
        if (!ok) s_err[(cyc + 1) % 4] = 1;
        else if (a == MATCH) begin
          s_push[(cyc + 2) % 4] = 1;
          s_data[(cyc + 2) % 4] = {a, c};
        end
      end
      prev_v = fvalid;
      prev_f = frame;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] head;
    head = (mq.size() > 0) ? mq[0] : m_last;
    chk("valid", 32'(o_valid), 32'(mq.size() > 0));
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("addr",  32'(o_addr),  32'(head[15:8]));
    chk("cmd",   32'(o_cmd),   32'(head[7:0]));
    chk("ovf",   32'(o_ovf),   32'(m_ovf));
    chk("err",   32'(o_err),   32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic ticks(int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    int unsigned r;
    rst_n = 1'b0; fvalid = 1'b0; frame = '0; clr = 1'b0; ready = 1'b0;
    ticks(2);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_err",   32'(o_err),   0);
    rst_n = 1'b1;

    // Basic accept
    ready = 1'b1; fvalid = 1'b1; frame = 32'hF708FB04;
    ticks(2);
    chk("basic_pre", 32'(o_valid), 0);
    tick();
    chk("basic_valid", 32'(o_valid), 1);
    chk("basic_addr",  32'(o_addr),  32'h04);
    chk("basic_cmd",   32'(o_cmd),   32'h08);
    tick();
    chk("basic_drain", 32'(o_count), 0);

    // Validation failure then a good frame held unchanged
    frame = 32'hF708FA04;
    ticks(3);
    chk("bad_addr_err", 32'(o_err), 1);
    frame = 32'hF708FB04;
    ticks(6);

    // Address filter: 0x05 dropped silently, 0x04 accepted
    frame = mk(8'h05, 8'h33, 1, 1);
    ticks(4);
    chk("filter_err", 32'(o_err), 1);
    frame = mk(8'h04, 8'h33, 1, 1);
    ticks(4);

    // Overflow
    ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      frame = mk(8'h04, 8'h10 + 8'(i), 1, 1);
      tick();
    end
    ticks(3);
    chk("ovf_count", 32'(o_count), 4);
    chk("ovf_flag",  32'(o_ovf),   1);
    ready = 1'b1;
    ticks(5);

    // Full FIFO with pop coincident with a push
    ready = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      frame = mk(8'h04, 8'h20 + 8'(i), 1, 1);
      tick();
    end
    tick();
    chk("simul_full", 32'(o_count), 4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("simul_count", 32'(o_count), 4);
    chk("simul_ovf",   32'(o_ovf),   0);
    ready = 1'b1;
    ticks(6);

    // Error counter saturation
    for (int unsigned i = 0; i < 260; i++) begin
      frame = mk(8'h04, 8'(i), 1, 0);
      tick();
    end
    ticks(2);
    chk("err_sat", 32'(o_err), 255);

    // Clear coincident with a push
    ready = 1'b0;
    frame = mk(8'h04, 8'h30, 1, 1);
    ticks(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", 32'(o_count), 0);
    chk("clr_err",   32'(o_err),   0);
    chk("clr_ovf",   32'(o_ovf),   0);
    ticks(2);

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      fvalid = 1'b1;
      case (r)
        0, 1:    ; // hold current frame
        2, 3, 4: frame = mk(MATCH, 8'($urandom), 1, 1);
        5:       frame = mk(8'($urandom), 8'($urandom), 1, 1);
        6:       frame = mk(MATCH, 8'($urandom), 1, 0);
        7:       frame = mk(8'($urandom), 8'($urandom), 0, 1);
        default: fvalid = ($urandom_range(0, 1) == 1);
      endcase
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr = 1'b0;

    // Reset in the middle of the pipeline
    ready = 1'b0;
    fvalid = 1'b1;
    frame = mk(MATCH, 8'h55, 1, 1); tick();
    frame = mk(MATCH, 8'h56, 1, 1); tick();
    frame = mk(MATCH, 8'h57, 1, 0); tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_count", 32'(o_count), 0);
    chk("mrst_addr",  32'(o_addr),  0);
    chk("mrst_cmd",   32'(o_cmd),   0);
    chk("mrst_ovf",   32'(o_ovf),   0);
    chk("mrst_err",   32'(o_err),   0);
    rst_n = 1'b1;
    // Frame already valid after reset still counts as a new event.
    frame = mk(MATCH, 8'h58, 1, 1);
    ticks(3);
    chk("post_rst_event", 32'(o_count), 1);
    ready = 1'b1;
    ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ir_cmd_decoder.md
# ir_cmd_decoder

Downstream stage of the NEC IR receiver. It watches the receiver's `o_rx_valid` / `o_rx_frame` pair and detects each newly decoded frame. It checks the address byte against its inverse (the receiver checks only the command) and applies an optional address filter. Accepted {address, command} pairs are queued in a small FIFO with a ready/valid output to the application logic on the DE1-SoC.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width of each NEC field; frame width is `DATA_WIDTH*4`.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ADDR_CHK_EN`, 1: 1 requires address == ~inverse-address; 0 skips the check (extended-NEC remotes).
- `ADDR_FILTER_EN`, 0: 1 drops frames whose address ≠ `ADDR_MATCH`.
- `ADDR_MATCH`, 8'h00: address accepted when filtering is enabled.

Ports:
- `i_clkDiv_dec_clk`, in, 1: the receiver's divided clock; the only clock.
- `i_dec_rst_n`, in, 1: synchronous reset, active low.
- `i_dec_frame_valid`, in, 1: receiver `o_rx_valid` (a level; sticky once set).
- `i_dec_frame`, in, `DATA_WIDTH*4`: receiver `o_rx_frame`; [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
- `i_dec_clr`, in, 1: synchronous clear of the FIFO, overflow flag and error counter.
- `i_dec_ready`, in, 1: consumer ready.
- `o_dec_valid`, out, 1: FIFO head is valid.
- `o_dec_addr`, out, `DATA_WIDTH`: head address.
- `o_dec_cmd`, out, `DATA_WIDTH`: head command.
- `o_dec_count`, out, `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `o_dec_overflow`, out, 1: sticky; set when a valid frame is dropped because the FIFO is full.
- `o_dec_err_cnt`, out, 8: count of frames that failed validation; saturates at 255.

## Operation
- **Stage A (capture):** registers `i_dec_frame_valid` and `i_dec_frame` into `valid_q`/`frame_q`, and keeps the previous values in `valid_qq`/`frame_qq`.
  - New-frame event = `valid_q & (!valid_qq | frame_q != frame_qq)`.
  - A repeated, identical frame produces no event; this is accepted behaviour.
- **Stage B (validate):** on an event, registers the frame together with `ok`.
  - `ok` = cmd == ~inverse-cmd, AND (`!ADDR_CHK_EN` OR addr == ~inverse-addr).
  - `!ok`: increments `o_dec_err_cnt`, saturating at 255; no push.
  - `ok` but the address filter rejects the frame: silently discarded; no error count, no push.
- **Stage C (push):** writes {addr, cmd} to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and `o_dec_overflow` is set.
- The pipeline is fully pipelined and accepts one event per cycle; it never stalls.
- **FIFO:**
  - Pop occurs when `o_dec_valid & i_dec_ready`.
  - Push and pop in the same cycle when full: both succeed and count is unchanged.
  - Push and pop in the same cycle when empty: the push lands, the pop is ignored, and count becomes 1.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Output handshake:** `o_dec_addr`/`o_dec_cmd` are driven from the head entry. They hold stable while `o_dec_valid & !i_dec_ready`; when the FIFO is empty, they hold the last popped value.
- **`i_dec_clr`:** empties the FIFO and clears the overflow flag and error counter. A push or error increment in the same cycle is lost; clear wins. Pipeline stages A and B are not cleared.

## Timing
- Reset (`i_dec_rst_n` low at a rising edge): all pipeline registers, pointers and outputs are 0. This covers `o_dec_valid`, `o_dec_addr`, `o_dec_cmd`, `o_dec_count`, `o_dec_overflow` and `o_dec_err_cnt`.
- Reset asserted mid-pipeline discards in-flight frames and FIFO contents.
- Latency: let edge E0 be the edge that samples a new `i_dec_frame`.
  - The event is registered in stage B at E1.
  - The FIFO write happens at E2.
  - `o_dec_valid` is high after E2 if the FIFO was empty.
  - `o_dec_err_cnt` updates at E1 for an invalid frame.
- Throughput: one push and one pop per cycle.
- `o_dec_count` and `o_dec_overflow` update on the same edge as the push or pop that changes them.
- The first frame after reset is an event even if `i_dec_frame_valid` is already high, because `valid_qq` resets to 0.

## Structure
- Package `ir_pkg` holds:
  - NEC field offsets: `ADDR_LSB`=0, `NADDR_LSB`=8, `CMD_LSB`=16, `NCMD_LSB`=24.
  - `typedef struct packed {logic [7:0] addr; logic [7:0] cmd;} ir_cmd_t`.
  - Shared with `ir_rx` if it is refactored.
- Sub-module `ir_sync_fifo`:
  - Parameterised by width and depth.
  - Synchronous active-low reset plus synchronous clear.
  - Provides count, full and empty outputs.

## Test plan
- **Basic accept:** hold `i_dec_ready`=1 and drive `i_dec_frame`=32'hF708FB04 with valid rising. Expect exactly one `o_dec_valid` pulse 3 edges later with addr=8'h04, cmd=8'h08; count returns to 0.
- **Validation failures:** with `ADDR_CHK_EN`=1, drive frame 32'hF708FA04 (bad ~addr). Expect no push and `o_dec_err_cnt`=1. Then drive 32'hF708FB04, then 32'hF708FB04 again unchanged. Expect one push and no second event.
- **Address filter:** with `ADDR_FILTER_EN`=1 and `ADDR_MATCH`=8'h04, drive frames for addr 0x05 and 0x04. Expect only addr 0x04 pushed and err_cnt unchanged.
- **Overflow:** with `i_dec_ready`=0 and `FIFO_DEPTH`=4, deliver 5 distinct valid frames. Expect count=4 and `o_dec_overflow`=1. Popping returns the first four frames in order.
- **Simultaneous events:** with the FIFO full, assert `i_dec_ready`=1 on the same cycle as a stage-C push. Expect count to stay 4, no overflow, and correct order.
- **Clear, saturation and mid-operation reset:**
  - Force 260 invalid frames. Expect err_cnt=255.
  - Pulse `i_dec_clr` coincident with a push. Expect count=0, err_cnt=0, overflow=0.
  - Assert reset mid-pipeline. Expect all outputs 0 on the next edge.
